// File: rtl/cpu1_oci_monitor_sequencer.sv
// OCI monitor sequencer: converts JTAG sysclk-side action strobes into
// single-word OCI debug-memory transactions (req/ack with timeout abort),
// auto-increments the word address, and reports ready/error status.
module cpu1_oci_monitor_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic              cmd_dropped
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  tcnt;
  logic              timeout_hit;

  // Bits of jdo that carry no command information.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[35:32]};

  // tcnt holds (req cycles elapsed - 1); this is the last cycle an ack may arrive.
  assign timeout_hit = (tcnt == CNT_W'(TIMEOUT - 1));

  // Command sequencing, memory handshake, address increment and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      tcnt          <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      busy          <= 1'b0;
      cmd_dropped   <= 1'b0;
    end else begin
      cmd_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (take_action_ocimem_a) begin
            addr          <= jdo[ADDR_W-1:0];
            monitor_error <= 1'b0;
            cmd_dropped   <= take_action_ocimem_b;
            if (jdo[36]) begin
              state         <= READ;
              mem_req       <= 1'b1;
              busy          <= 1'b1;
              mem_we        <= 1'b0;
              mem_addr      <= jdo[ADDR_W-1:0];
              tcnt          <= '0;
              monitor_ready <= 1'b0;
            end else begin
              // Address-only load completes immediately.
              monitor_ready <= 1'b1;
            end
          end else if (take_action_ocimem_b) begin
            state         <= WRITE;
            mem_wdata     <= jdo[31:0];
            mem_req       <= 1'b1;
            busy          <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= addr;
            tcnt          <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
          end
        end
        READ, WRITE: begin
          cmd_dropped <= take_action_ocimem_a | take_action_ocimem_b;
          if (mem_ack) begin
            if (state == READ) begin
              MonDReg <= mem_rdata;
            end
            addr          <= addr + 1'b1;
            state         <= IDLE;
            mem_req       <= 1'b0;
            busy          <= 1'b0;
            monitor_ready <= 1'b1;
          end else if (timeout_hit) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            busy          <= 1'b0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
